// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address generator: log2 helper, sequencer
// state encoding and parameter legality checks.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } fsm_state_t;

    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit agu_params_legal(input int n, input int lanes);
        return is_pow2(n) && (n >= 4) && is_pow2(lanes) && (lanes <= n / 2);
    endfunction

    // Gap counter holds STAGE_GAP-1 down to 0; keep at least one bit.
    function automatic int gap_cnt_width(input int gap);
        return (gap <= 2) ? 1 : log2_ceil(gap);
    endfunction

endpackage

// File: rtl/fft_agu_lane.sv
// Per-lane radix-2 address mapping: both butterfly sample addresses are the
// pair index with a 0/1 appended, rotated left by the stage number.
module fft_agu_lane #(
    parameter int LOG2N = 10
) (
    input  logic [LOG2N-2:0] pair_id,
    input  logic [LOG2N-1:0] stage,
    output logic [LOG2N-1:0] address1,
    output logic [LOG2N-1:0] address2,
    output logic [LOG2N-1:0] twiddle_address
);

    logic [2*LOG2N-1:0] rot1;
    logic [2*LOG2N-1:0] rot2;
    logic [LOG2N-1:0]   tw_mask;

    always_comb begin
        // Shifting the doubled word and keeping the upper half is a rotate.
        rot1            = {pair_id, 1'b0, pair_id, 1'b0} << stage;
        rot2            = {pair_id, 1'b1, pair_id, 1'b1} << stage;
        address1        = rot1[2*LOG2N-1 -: LOG2N];
        address2        = rot2[2*LOG2N-1 -: LOG2N];
        tw_mask         = ~({LOG2N{1'b1}} << stage);
        twiddle_address = {1'b0, pair_id} & tw_mask;
    end

endmodule

// File: rtl/fft_agu_seq.sv
// FFT address-generation sequencer: walks every stage and butterfly of an
// N-point radix-2 transform, LANES butterflies per beat, with optional gaps.
//
// state | meaning
// IDLE  | waiting for start, outputs idle
// RUN   | presenting address beats, advancing on out_ready
// GAP   | stage boundary bubble of STAGE_GAP cycles
// FIN   | one-cycle done pulse, then back to IDLE
module fft_agu_seq
    import fft_pkg::*;
#(
    parameter int N         = 1024,
    parameter int LANES     = 1,
    parameter int STAGE_GAP = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [log2_ceil(N)-1:0]         stage,
    output logic [LANES*log2_ceil(N)-1:0]   address1,
    output logic [LANES*log2_ceil(N)-1:0]   address2,
    output logic [LANES*log2_ceil(N)-1:0]   twiddle_address,
    output logic                            last,
    output logic                            done
);

    localparam int LOG2N = log2_ceil(N);
    localparam int BW    = LOG2N - 1;
    localparam int GW    = gap_cnt_width(STAGE_GAP);

    localparam logic [BW-1:0]    BASE_LAST  = BW'(N / 2 - LANES);
    localparam logic [BW-1:0]    BASE_STEP  = BW'(LANES);
    localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);
    localparam logic [GW-1:0]    GAP_LOAD   = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

    if (!agu_params_legal(N, LANES)) begin : g_param_check
        $error("fft_agu_seq: N must be a power of two >= 4, LANES a power of two <= N/2");
    end

    fsm_state_t       state_q;
    fsm_state_t       state_d;
    logic [LOG2N-1:0] stage_q;
    logic [LOG2N-1:0] stage_d;
    logic [BW-1:0]    base_q;
    logic [BW-1:0]    base_d;
    logic [GW-1:0]    gap_q;
    logic [GW-1:0]    gap_d;
    logic             load;
    logic             beat_is_last;

    logic [LANES*LOG2N-1:0] addr1_d;
    logic [LANES*LOG2N-1:0] addr2_d;
    logic [LANES*LOG2N-1:0] tw_d;

    assign beat_is_last = (stage_q == STAGE_LAST) && (base_q == BASE_LAST);

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        base_d  = base_q;
        gap_d   = gap_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                    base_d  = '0;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (beat_is_last) begin
                        state_d = FIN;
                    end else begin
                        load = 1'b1;
                        if (base_q == BASE_LAST) begin
                            base_d  = '0;
                            stage_d = stage_q + LOG2N'(1);
                            if (STAGE_GAP > 0) begin
                                state_d = GAP;
                                gap_d   = GAP_LOAD;
                            end
                        end else begin
                            base_d = base_q + BASE_STEP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = RUN;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lanes map the next beat so the address registers load it directly.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [BW-1:0] pair_id;
        assign pair_id = base_d + BW'(k);

        fft_agu_lane #(
            .LOG2N(LOG2N)
        ) u_lane (
            .pair_id         (pair_id),
            .stage           (stage_d),
            .address1        (addr1_d[k*LOG2N +: LOG2N]),
            .address2        (addr2_d[k*LOG2N +: LOG2N]),
            .twiddle_address (tw_d[k*LOG2N +: LOG2N])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            stage_q         <= '0;
            base_q          <= '0;
            gap_q           <= '0;
            out_valid       <= 1'b0;
            last            <= 1'b0;
            address1        <= '0;
            address2        <= '0;
            twiddle_address <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            base_q    <= base_d;
            gap_q     <= gap_d;
            out_valid <= (state_d == RUN);
            last      <= (state_d == RUN) && (stage_d == STAGE_LAST) && (base_d == BASE_LAST);
            if (load) begin
                address1        <= addr1_d;
                address2        <= addr2_d;
                twiddle_address <= tw_d;
            end
        end
    end

    assign stage = stage_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == FIN);

endmodule

// File: tb/tb_fft_agu_seq.sv
// Directed bench for fft_agu_seq: three N=8 instances (1 lane, 2 lanes,
// stage gap 3) checked against hand-computed beat tables.
module tb_fft_agu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start1, ready1, busy1, valid1, last1, done1;
    logic [2:0] stage1, a1_1, a2_1, tw_1;

    logic       start2, ready2, busy2, valid2, last2, done2;
    logic [2:0] stage2;
    logic [5:0] a1_2, a2_2, tw_2;

    logic       start3, ready3, busy3, valid3, last3, done3;
    logic [2:0] stage3, a1_3, a2_3, tw_3;

    fft_agu_seq #(.N(8), .LANES(1), .STAGE_GAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .out_valid(valid1),
        .out_ready(ready1), .stage(stage1), .address1(a1_1), .address2(a2_1),
        .twiddle_address(tw_1), .last(last1), .done(done1));

    fft_agu_seq #(.N(8), .LANES(2), .STAGE_GAP(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .out_valid(valid2),
        .out_ready(ready2), .stage(stage2), .address1(a1_2), .address2(a2_2),
        .twiddle_address(tw_2), .last(last2), .done(done2));

    fft_agu_seq #(.N(8), .LANES(1), .STAGE_GAP(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .out_valid(valid3),
        .out_ready(ready3), .stage(stage3), .address1(a1_3), .address2(a2_3),
        .twiddle_address(tw_3), .last(last3), .done(done3));

    typedef struct packed {
        logic [2:0] stage;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [2:0] tw;
        logic       last;
    } beat1_t;

    typedef struct packed {
        logic [2:0] stage;
        logic [5:0] a1;
        logic [5:0] a2;
        logic [5:0] tw;
        logic       last;
    } beat2_t;

    beat1_t tab1[12];
    beat2_t tab2[6];

    int n_cmp;
    int n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Full N=8 single-lane sequence on dut1, optionally with random back-pressure.
    task automatic run1(input bit stall);
        int beat;
        int last_cyc;
        int dones;
        bit snap_ok;
        logic [12:0] snap;
        logic [12:0] cur;
        beat = 0; last_cyc = -1; dones = 0; snap_ok = 1'b0; snap = '0;
        @(negedge clk);
        start1 = 1'b1;
        ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("t1_first_valid", valid1, 1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            cur = {stage1, a1_1, a2_1, tw_1, last1};
            if (snap_ok) begin
                check("t1_stall_valid", valid1, 1);
                check("t1_stall_hold", cur, snap);
            end
            if (done1) begin
                dones++;
                check("t1_done_cycle", cyc, last_cyc + 1);
            end
            if (last_cyc >= 0 && cyc == last_cyc + 1) check("t1_busy_fin", busy1, 1);
            if (last_cyc >= 0 && cyc == last_cyc + 2) begin
                check("t1_busy_idle", busy1, 0);
                break;
            end
            ready1 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            snap_ok = 1'b0;
            if (valid1 && ready1) begin
                if (beat < 12) begin
                    check($sformatf("t1_stage[%0d]", beat), stage1, tab1[beat].stage);
                    check($sformatf("t1_addr1[%0d]", beat), a1_1, tab1[beat].a1);
                    check($sformatf("t1_addr2[%0d]", beat), a2_1, tab1[beat].a2);
                    check($sformatf("t1_tw[%0d]", beat), tw_1, tab1[beat].tw);
                    check($sformatf("t1_last[%0d]", beat), last1, tab1[beat].last);
                end
                if (beat == 11) last_cyc = cyc;
                beat++;
            end else if (valid1) begin
                snap = cur;
                snap_ok = 1'b1;
            end
            @(negedge clk);
        end
        ready1 = 1'b1;
        check("t1_beat_count", beat, 12);
        check("t1_done_count", dones, 1);
    endtask

    initial begin
        int beat;
        int dones;
        int d;
        n_cmp = 0;
        n_err = 0;

        tab1[0]  = '{3'd0, 3'd0, 3'd1, 3'd0, 1'b0};
        tab1[1]  = '{3'd0, 3'd2, 3'd3, 3'd0, 1'b0};
        tab1[2]  = '{3'd0, 3'd4, 3'd5, 3'd0, 1'b0};
        tab1[3]  = '{3'd0, 3'd6, 3'd7, 3'd0, 1'b0};
        tab1[4]  = '{3'd1, 3'd0, 3'd2, 3'd0, 1'b0};
        tab1[5]  = '{3'd1, 3'd4, 3'd6, 3'd1, 1'b0};
        tab1[6]  = '{3'd1, 3'd1, 3'd3, 3'd0, 1'b0};
        tab1[7]  = '{3'd1, 3'd5, 3'd7, 3'd1, 1'b0};
        tab1[8]  = '{3'd2, 3'd0, 3'd4, 3'd0, 1'b0};
        tab1[9]  = '{3'd2, 3'd1, 3'd5, 3'd1, 1'b0};
        tab1[10] = '{3'd2, 3'd2, 3'd6, 3'd2, 1'b0};
        tab1[11] = '{3'd2, 3'd3, 3'd7, 3'd3, 1'b1};

        tab2[0] = '{3'd0, {3'd2, 3'd0}, {3'd3, 3'd1}, {3'd0, 3'd0}, 1'b0};
        tab2[1] = '{3'd0, {3'd6, 3'd4}, {3'd7, 3'd5}, {3'd0, 3'd0}, 1'b0};
        tab2[2] = '{3'd1, {3'd4, 3'd0}, {3'd6, 3'd2}, {3'd1, 3'd0}, 1'b0};
        tab2[3] = '{3'd1, {3'd5, 3'd1}, {3'd7, 3'd3}, {3'd1, 3'd0}, 1'b0};
        tab2[4] = '{3'd2, {3'd1, 3'd0}, {3'd5, 3'd4}, {3'd1, 3'd0}, 1'b0};
        tab2[5] = '{3'd2, {3'd3, 3'd2}, {3'd7, 3'd6}, {3'd3, 3'd2}, 1'b1};

        rst_n  = 1'b0;
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        ready1 = 1'b1; ready2 = 1'b1; ready3 = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_busy", busy1, 0);
        check("rst_valid", valid1, 0);
        check("rst_last", last1, 0);
        check("rst_done", done1, 0);
        check("rst_stage", stage1, 0);
        check("rst_addr1", a1_1, 0);
        check("rst_addr2", a2_1, 0);
        check("rst_tw", tw_1, 0);
        check("rst_addr2_l2", a2_2, 0);
        check("rst_busy_gap", busy3, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start", valid1, 0);

        run1(1'b0);

        // Two lanes per beat.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        beat = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            check($sformatf("t2_done@%0d", cyc), done2, (cyc == 6));
            if (valid2) begin
                if (beat < 6) begin
                    check($sformatf("t2_stage[%0d]", beat), stage2, tab2[beat].stage);
                    check($sformatf("t2_addr1[%0d]", beat), a1_2, tab2[beat].a1);
                    check($sformatf("t2_addr2[%0d]", beat), a2_2, tab2[beat].a2);
                    check($sformatf("t2_tw[%0d]", beat), tw_2, tab2[beat].tw);
                    check($sformatf("t2_last[%0d]", beat), last2, tab2[beat].last);
                end
                beat++;
            end
            @(negedge clk);
        end
        check("t2_beat_count", beat, 6);

        // Stage gap of 3: beats in cycles 0-3, 7-10, 14-17, done at 18.
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        beat = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            check($sformatf("t3_valid@%0d", cyc), valid3, (cyc < 18) && ((cyc % 7) < 4));
            check($sformatf("t3_done@%0d", cyc), done3, (cyc == 18));
            if (valid3 && beat < 12) begin
                check($sformatf("t3_stage[%0d]", beat), stage3, tab1[beat].stage);
                check($sformatf("t3_addr1[%0d]", beat), a1_3, tab1[beat].a1);
                check($sformatf("t3_addr2[%0d]", beat), a2_3, tab1[beat].a2);
                check($sformatf("t3_tw[%0d]", beat), tw_3, tab1[beat].tw);
                check($sformatf("t3_last[%0d]", beat), last3, tab1[beat].last);
            end
            if (valid3) beat++;
            @(negedge clk);
        end
        check("t3_beat_count", beat, 12);
        check("t3_busy_after", busy3, 0);

        // Random back-pressure.
        run1(1'b1);

        // Reset while beat 6 is presented, then restart.
        @(negedge clk);
        start1 = 1'b1;
        ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_pre_stage", stage1, tab1[6].stage);
        check("t4_pre_addr1", a1_1, tab1[6].a1);
        rst_n = 1'b0;
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done1) dones++;
            check("t4_rst_busy", busy1, 0);
            check("t4_rst_valid", valid1, 0);
        end
        check("t4_rst_addr1", a1_1, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done1) dones++;
        end
        check("t4_no_done", dones, 0);
        check("t4_idle_busy", busy1, 0);
        run1(1'b0);

        // start held high across a whole sequence.
        @(negedge clk);
        start1 = 1'b1;
        ready1 = 1'b1;
        beat = 0;
        d = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (d < 0) begin
                if (done1) begin
                    d = cyc;
                    check("t5_beats_before_done", beat, 12);
                end else if (valid1) begin
                    if (beat < 12) begin
                        check($sformatf("t5_stage[%0d]", beat), stage1, tab1[beat].stage);
                        check($sformatf("t5_addr1[%0d]", beat), a1_1, tab1[beat].a1);
                    end
                    beat++;
                end
            end else if (cyc == d + 1) begin
                check("t5_gap_valid", valid1, 0);
                check("t5_gap_busy", busy1, 0);
            end else if (cyc == d + 2) begin
                check("t5_restart_valid", valid1, 1);
                check("t5_restart_stage", stage1, 0);
                check("t5_restart_addr1", a1_1, 0);
                check("t5_restart_addr2", a2_1, 1);
                break;
            end
        end
        check("t5_done_cycle", d, 12);
        start1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_agu_seq.md
FFT_AGU_SEQ -- requirements
Module: fft_agu_seq

Interface
REQ-001 Parameter N, default 1024: FFT points; power of two, at least 4.
REQ-002 Parameter LANES, default 1: butterflies issued per beat; power of two, at most N/2.
REQ-003 Parameter STAGE_GAP, default 0: idle cycles inserted between stages for butterfly write-back latency.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 Port start, input, 1: request a full transform sequence.
REQ-007 Port busy, output, 1: sequence in progress.
REQ-008 Port out_valid, output, 1: address beat present.
REQ-009 Port out_ready, input, 1: consumer accepts beat.
REQ-010 Port stage, output, log2N: stage of the current beat.
REQ-011 Port address1, output, LANES*log2N: first sample address per lane; lane k is in bits [k*log2N +: log2N].
REQ-012 Port address2, output, LANES*log2N: second sample address per lane.
REQ-013 Port twiddle_address, output, LANES*log2N: twiddle ROM address per lane.
REQ-014 Port last, output, 1: current beat is the final beat of the sequence.
REQ-015 Port done, output, 1: one-cycle pulse when the sequence completes.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, GAP and FIN.
REQ-017 In IDLE, start=1 SHALL load stage=0 and base=0 and enter RUN; start is ignored in all other states.
REQ-018 First out_valid SHALL assert the cycle after start is sampled; the output is registered and latency is 1.
REQ-019 Lane k pair_id = base+k, with width log2N-1.
REQ-020 address1 SHALL equal rotate-left of (2*pair_id), within log2N bits, by stage.
REQ-021 address2 SHALL equal rotate-left of (2*pair_id+1), within log2N bits, by stage.
REQ-022 twiddle_address SHALL equal pair_id AND ((1<<stage)-1), zero-extended to log2N bits.
REQ-023 A beat is accepted when out_valid and out_ready are both 1; all outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 On acceptance, base SHALL increase by LANES; at base=N/2-LANES, base SHALL wrap to 0 and stage SHALL increment.
REQ-025 At a stage boundary with STAGE_GAP>0, the FSM SHALL enter GAP, deassert out_valid for exactly STAGE_GAP cycles, then return to RUN.
REQ-026 With STAGE_GAP=0, beats SHALL be back-to-back with no bubble.
REQ-027 last SHALL be 1 only for the beat with stage=log2N-1 and base=N/2-LANES.
REQ-028 Acceptance of the last beat SHALL enter FIN; FIN SHALL pulse done=1 for one cycle and return to IDLE.
REQ-029 A sequence SHALL issue exactly log2N*N/(2*LANES) beats.
REQ-030 busy SHALL be 1 in RUN, GAP and FIN, and 0 in IDLE.
REQ-031 start asserted in the same cycle as done SHALL be ignored; a new start is accepted only in IDLE.
REQ-032 All counters SHALL be sized from N and LANES with no truncation at N=2^16.

Reset
REQ-033 rst_n=0 at any edge SHALL force IDLE and clear busy, out_valid, last and done, regardless of the current state.
REQ-034 On that same edge, stage, base, address1, address2, twiddle_address and the gap counter SHALL be set to 0.
REQ-035 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse.

Structure
REQ-036 Shared package fft_pkg SHALL hold the log2 helper, the FSM state enum and the parameter legality checks (power-of-two, LANES at most N/2).
REQ-037 Per-lane address/twiddle mapping SHALL be the combinational sub-module fft_agu_lane, instantiated LANES times.
REQ-038 The sequencer, gap counter and output register SHALL reside in fft_agu_seq.

Verification
REQ-039 N=8, LANES=1, STAGE_GAP=0, out_ready=1, start pulsed: 12 beats; beat 0 gives stage 0, addresses 0/1, tw 0; beat 5 gives stage 1, addresses 4/6, tw 1; beat 11 gives stage 2, addresses 3/7, tw 3, last=1; done pulses one cycle later.
REQ-040 N=8, LANES=2: 6 beats; beat 0 lanes give addresses (0,1) and (2,3); beat 2 lanes give stage 1, addresses (0,2) and (4,6), tw (0,1).
REQ-041 N=8, STAGE_GAP=3: exactly 3 invalid cycles after beats 3 and 7; total 18 cycles from the first valid beat to done.
REQ-042 out_ready toggled pseudo-randomly: outputs stable while stalled; beat sequence identical to the out_ready=1 run.
REQ-043 rst_n=0 at beat 6, then start: no done pulse for the aborted run; the restarted sequence begins at stage 0, address 0/1.
REQ-044 start held high throughout: second sequence begins only after done; start during RUN has no effect.
